branch_ctrl: RTL and testbench

Branch resolution controller for the RV32I core. It accepts one control-transfer instruction per handshake (BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL, JALR) and drives the shared brcomp comparator, selecting br_unsigned from funct3. It registers the taken/target decision and issues a PC redirect plus a counted front-end flush. Static predict-not-taken is assumed upstream. Saturating branch/taken performance counters are kept for the CSR block.

---
 rtl/brctrl_pkg.sv | 19 +
 rtl/brcomp.sv | 17 +
 rtl/branch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_branch_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/brctrl_pkg.sv
// Shared types and constants for the branch resolution controller.
package brctrl_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    StIdle,
    StResolve,
    StFlush
  } state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/brcomp.sv
// Shared branch comparator: equality plus signed/unsigned less-than.
module brcomp
  import brctrl_pkg::*;
(
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            br_unsigned,
  output logic            br_equal,
  output logic            br_less
);

  always_comb begin
    br_equal = (rs1 == rs2);
    br_less  = br_unsigned ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
  end

endmodule

// File: rtl/branch_ctrl.sv
// Resolves one control transfer per handshake, issues a PC redirect with a counted
// front-end flush, and keeps saturating branch/taken counters.
module branch_ctrl
  import brctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_is_branch,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_imm,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic [XLEN-1:0]  i_rs2_data,
  output logic             o_done,
  output logic             o_taken,
  output logic             o_redirect,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_flush,
  output logic             o_misalign,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_taken_cnt
);

  // With a single flush cycle the RESOLVE cycle covers it and FLUSH is skipped.
  localparam bit         HasFlushState = (FLUSH_CYCLES > 1);
  localparam logic [3:0] FlushLast     = 4'(HasFlushState ? FLUSH_CYCLES - 2 : 0);

  state_e            state_q;
  logic [3:0]        flush_cnt_q;
  logic              done_q, taken_q, redirect_q, misalign_q, illegal_q, flush_q;
  logic [XLEN-1:0]   redirect_pc_q;
  logic [CNT_W-1:0]  br_cnt_q, taken_cnt_q;

  logic              br_equal, br_less;
  logic              cond_taken, f3_illegal;
  logic              is_typed, taken, illegal, accept;
  logic [XLEN-1:0]   target;

  brcomp u_brcomp (
    .rs1         (i_rs1_data),
    .rs2         (i_rs2_data),
    .br_unsigned (i_funct3[1]),
    .br_equal    (br_equal),
    .br_less     (br_less)
  );

  always_comb begin
    cond_taken = 1'b0;
    f3_illegal = 1'b0;
    case (i_funct3)
      F3_BEQ:           cond_taken = br_equal;
      F3_BNE:           cond_taken = !br_equal;
      F3_BLT, F3_BLTU:  cond_taken = br_less;
      F3_BGE, F3_BGEU:  cond_taken = !br_less;
      default:          f3_illegal = 1'b1;
    endcase

    is_typed = i_is_jalr | i_is_jal | i_is_branch;
    target   = i_pc + i_imm;
    taken    = 1'b0;
    illegal  = 1'b0;
    if (i_is_jalr) begin
      target    = i_rs1_data + i_imm;
      target[0] = 1'b0;
      taken     = 1'b1;
    end else if (i_is_jal) begin
      taken = 1'b1;
    end else if (i_is_branch) begin
      taken   = cond_taken;
      illegal = f3_illegal;
    end
  end

  assign o_ready = (state_q == StIdle) || ((state_q == StResolve) && !redirect_q);
  assign accept  = i_valid && o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      flush_cnt_q   <= 4'd0;
      done_q        <= 1'b0;
      taken_q       <= 1'b0;
      redirect_q    <= 1'b0;
      misalign_q    <= 1'b0;
      illegal_q     <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      done_q     <= 1'b0;
      taken_q    <= 1'b0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      if (accept) begin
        state_q       <= StResolve;
        done_q        <= 1'b1;
        taken_q       <= taken;
        redirect_q    <= taken && !target[1];
        misalign_q    <= taken && target[1];
        illegal_q     <= illegal;
        flush_q       <= taken && !target[1];
        redirect_pc_q <= target;
      end else begin
        unique case (state_q)
          StIdle: flush_q <= 1'b0;
          StResolve: begin
            if (redirect_q && HasFlushState) begin
              state_q     <= StFlush;
              flush_cnt_q <= FlushLast;
            end else begin
              state_q <= StIdle;
              flush_q <= 1'b0;
            end
          end
          StFlush: begin
            if (flush_cnt_q == 4'd0) begin
              state_q <= StIdle;
              flush_q <= 1'b0;
            end else begin
              flush_cnt_q <= flush_cnt_q - 4'd1;
            end
          end
          default: begin
            state_q <= StIdle;
            flush_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else if (accept) begin
      if (is_typed && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (taken && (taken_cnt_q != '1)) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
    end
  end

  assign o_done        = done_q;
  assign o_taken       = taken_q;
  assign o_redirect    = redirect_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_flush       = flush_q;
  assign o_misalign    = misalign_q;
  assign o_illegal     = illegal_q;
  assign o_br_cnt      = br_cnt_q;
  assign o_taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed vector table, corner sequences and
// randomized traffic against a behavioural model.
module tb_branch_ctrl;

  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned CNT_W        = 4;
  localparam int          CNT_MAX      = 15;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic             i_is_branch = 1'b0, i_is_jal = 1'b0, i_is_jalr = 1'b0;
  logic [2:0]       i_funct3 = 3'b000;
  logic [31:0]      i_pc = '0, i_imm = '0, i_rs1_data = '0, i_rs2_data = '0;
  logic             o_done, o_taken, o_redirect, o_flush, o_misalign, o_illegal;
  logic [31:0]      o_redirect_pc;
  logic [CNT_W-1:0] o_br_cnt, o_taken_cnt;

  always #5 i_clk = ~i_clk;

  branch_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_is_branch   (i_is_branch),
    .i_is_jal      (i_is_jal),
    .i_is_jalr     (i_is_jalr),
    .i_funct3      (i_funct3),
    .i_pc          (i_pc),
    .i_imm         (i_imm),
    .i_rs1_data    (i_rs1_data),
    .i_rs2_data    (i_rs2_data),
    .o_done        (o_done),
    .o_taken       (o_taken),
    .o_redirect    (o_redirect),
    .o_redirect_pc (o_redirect_pc),
    .o_flush       (o_flush),
    .o_misalign    (o_misalign),
    .o_illegal     (o_illegal),
    .o_br_cnt      (o_br_cnt),
    .o_taken_cnt   (o_taken_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  // Model state: cycles of flush/stall still owed, and the expected counter values.
  int busy = 0;
  int exp_br = 0;
  int exp_tk = 0;

  typedef struct {
    logic        br, jal, jalr;
    logic [2:0]  f3;
    logic [31:0] pc, imm, rs1, rs2;
    logic        taken, redirect;
    logic [31:0] tgt;
    logic        misalign, illegal;
  } vec_t;

  vec_t tab[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic br, input logic jal, input logic jalr,
                                input logic [2:0] f3, input logic [31:0] pc,
                                input logic [31:0] imm, input logic [31:0] rs1,
                                input logic [31:0] rs2, output logic typed,
                                output logic taken, output logic illegal,
                                output logic [31:0] tgt);
    typed   = br | jal | jalr;
    taken   = 1'b0;
    illegal = 1'b0;
    tgt     = pc + imm;
    if (jalr) begin
      taken = 1'b1;
      tgt   = (rs1 + imm) & 32'hFFFF_FFFE;
    end else if (jal) begin
      taken = 1'b1;
    end else if (br) begin
      case (f3)
        3'd0:    taken = (rs1 == rs2);
        3'd1:    taken = (rs1 != rs2);
        3'd4:    taken = ($signed(rs1) < $signed(rs2));
        3'd5:    taken = ($signed(rs1) >= $signed(rs2));
        3'd6:    taken = (rs1 < rs2);
        3'd7:    taken = (rs1 >= rs2);
        default: illegal = 1'b1;
      endcase
    end
  endfunction

  task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                       input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    i_valid = v; i_is_branch = br; i_is_jal = jal; i_is_jalr = jalr; i_funct3 = f3;
    i_pc = pc; i_imm = imm; i_rs1_data = rs1; i_rs2_data = rs2;
  endtask

  // One clock with the current inputs, scored against the model.
  task automatic cycle_check();
    logic typed, taken, illegal, acc, redir;
    logic [31:0] tgt;
    check("ready", 32'(o_ready), 32'(busy == 0));
    acc = i_valid && (busy == 0);
    model(i_is_branch, i_is_jal, i_is_jalr, i_funct3, i_pc, i_imm, i_rs1_data, i_rs2_data,
          typed, taken, illegal, tgt);
    redir = taken && !tgt[1];
    @(posedge i_clk);
    #1;
    if (acc && typed && exp_br < CNT_MAX) exp_br++;
    if (acc && taken && exp_tk < CNT_MAX) exp_tk++;
    if (acc && redir) busy = FLUSH_CYCLES;
    else if (busy > 0) busy--;
    check("done", 32'(o_done), 32'(acc));
    if (acc) check("taken", 32'(o_taken), 32'(taken));
    check("redirect", 32'(o_redirect), 32'(acc && redir));
    if (acc && redir) check("redirect_pc", o_redirect_pc, tgt);
    check("misalign", 32'(o_misalign), 32'(acc && taken && tgt[1]));
    check("illegal", 32'(o_illegal), 32'(acc && illegal));
    check("flush", 32'(o_flush), 32'(busy > 0));
    check("br_cnt", 32'(o_br_cnt), 32'(exp_br));
    check("taken_cnt", 32'(o_taken_cnt), 32'(exp_tk));
  endtask

  task automatic wait_idle();
    i_valid = 1'b0;
    for (int k = 0; k < 20 && !o_ready; k++) cycle_check();
    check("wait_idle_ready", 32'(o_ready), 32'd1);
  endtask

  initial begin
    tab[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h20, 32'h5, 32'h5,
                1'b1, 1'b1, 32'h120, 1'b0, 1'b0};
    tab[1]  = '{1'b1, 1'b0, 1'b0, 3'b100, 32'h300, 32'h10, 32'hFFFF_FFFF, 32'h1,
                1'b1, 1'b1, 32'h310, 1'b0, 1'b0};
    tab[2]  = '{1'b1, 1'b0, 1'b0, 3'b110, 32'h300, 32'h10, 32'hFFFF_FFFF, 32'h1,
                1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    tab[3]  = '{1'b1, 1'b0, 1'b0, 3'b101, 32'h300, 32'h10, 32'hFFFF_FFFF, 32'h1,
                1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    tab[4]  = '{1'b1, 1'b0, 1'b0, 3'b111, 32'h400, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h1,
                1'b1, 1'b1, 32'h3F0, 1'b0, 1'b0};
    tab[5]  = '{1'b0, 1'b0, 1'b1, 3'b000, 32'h80, 32'h4, 32'h1001, 32'h0,
                1'b1, 1'b1, 32'h1004, 1'b0, 1'b0};
    tab[6]  = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h200, 32'h6, 32'h0, 32'h0,
                1'b1, 1'b0, 32'h0, 1'b1, 1'b0};
    tab[7]  = '{1'b1, 1'b0, 1'b0, 3'b010, 32'h500, 32'h8, 32'h1, 32'h2,
                1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    tab[8]  = '{1'b0, 1'b0, 1'b0, 3'b000, 32'h600, 32'h8, 32'h7, 32'h7,
                1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    tab[9]  = '{1'b1, 1'b0, 1'b0, 3'b001, 32'h700, 32'h8, 32'h3, 32'h3,
                1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    tab[10] = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h800, 32'h8, 32'h2000, 32'h2000,
                1'b1, 1'b1, 32'h2008, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_flush", 32'(o_flush), 32'd0);
    check("rst_redirect", 32'(o_redirect), 32'd0);
    check("rst_pc", o_redirect_pc, 32'd0);
    check("rst_br_cnt", 32'(o_br_cnt), 32'd0);
    check("rst_taken_cnt", 32'(o_taken_cnt), 32'd0);
    #3 i_rst_n = 1'b1;
    #1 check("rst_ready", 32'(o_ready), 32'd1);

    // Directed vector table; a not-taken entry leaves o_ready high so the next one
    // is accepted back-to-back in RESOLVE.
    for (int i = 0; i < 11; i++) begin
      wait_idle();
      drive(1'b1, tab[i].br, tab[i].jal, tab[i].jalr, tab[i].f3, tab[i].pc, tab[i].imm,
            tab[i].rs1, tab[i].rs2);
      cycle_check();
      check($sformatf("tab%0d_done", i), 32'(o_done), 32'd1);
      check($sformatf("tab%0d_taken", i), 32'(o_taken), 32'(tab[i].taken));
      check($sformatf("tab%0d_redirect", i), 32'(o_redirect), 32'(tab[i].redirect));
      if (tab[i].redirect) check($sformatf("tab%0d_pc", i), o_redirect_pc, tab[i].tgt);
      check($sformatf("tab%0d_misalign", i), 32'(o_misalign), 32'(tab[i].misalign));
      check($sformatf("tab%0d_illegal", i), 32'(o_illegal), 32'(tab[i].illegal));
      if (!tab[i].redirect) check($sformatf("tab%0d_ready", i), 32'(o_ready), 32'd1);
      i_valid = 1'b0;
    end

    // i_valid held through a flush must not be accepted until IDLE.
    wait_idle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h900, 32'h40, 32'h9, 32'h9);
    cycle_check();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 32'hA00, 32'h40, 32'h9, 32'h9);
    cycle_check();
    check("flushvalid_done", 32'(o_done), 32'd0);
    check("flushvalid_flush", 32'(o_flush), 32'd1);
    cycle_check();
    check("flushvalid_done2", 32'(o_done), 32'd0);
    cycle_check();
    check("flushvalid_accept", 32'(o_done), 32'd1);
    i_valid = 1'b0;

    // Counter saturation at 4 bits.
    for (int i = 0; i < 20; i++) begin
      wait_idle();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h1000, 32'h10, 32'h1, 32'h1);
      cycle_check();
      i_valid = 1'b0;
    end
    wait_idle();
    check("sat_br_cnt", 32'(o_br_cnt), 32'hF);
    check("sat_taken_cnt", 32'(o_taken_cnt), 32'hF);

    // Asynchronous reset during the second flush cycle.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h20, 32'h5, 32'h5);
    cycle_check();
    i_valid = 1'b0;
    cycle_check();
    check("pre_rst_flush", 32'(o_flush), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst_flush", 32'(o_flush), 32'd0);
    check("midrst_ready", 32'(o_ready), 32'd1);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_br_cnt", 32'(o_br_cnt), 32'd0);
    check("midrst_taken_cnt", 32'(o_taken_cnt), 32'd0);
    busy = 0; exp_br = 0; exp_tk = 0;
    #2 i_rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h20, 32'h5, 32'h5);
    cycle_check();
    check("postrst_taken", 32'(o_taken), 32'd1);
    check("postrst_pc", o_redirect_pc, 32'h120);
    i_valid = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  kind;
      logic [31:0] rs1, rs2, imm;
      kind = 3'($urandom_range(0, 7));
      rs1  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rs2  = ($urandom_range(0, 2) == 0) ? rs1 : $urandom;
      if ($urandom_range(0, 1) == 0) rs2 = 32'($urandom_range(0, 3));
      imm  = 32'($signed(12'($urandom))) & 32'hFFFF_FFFE;
      drive(($urandom_range(0, 3) != 0), kind[0], kind[1], kind[2],
            3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC, imm, rs1, rs2);
      cycle_check();
    end
    i_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
